// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the iterative inverse cipher.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEXP,
    ST_READY,
    ST_DEC,
    ST_DONE
  } aes_inv_state_t;

  // Entry 0 is unused; key-expansion step idx takes AES_RCON[idx/2].
  localparam logic [7:0] AES_RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r;
    case (b)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5;
      8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0;
      8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc;
      8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a;
      8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0;
      8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b;
      8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85;
      8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5;
      8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17;
      8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88;
      8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c;
      8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9;
      8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6;
      8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e;
      8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94;
      8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68;
      8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] r;
    case (b)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (used with 09, 0b, 0d, 0e) via repeated doubling.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last_i.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rkey_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [7:0] in_b [16];
  logic [7:0] k_b  [16];
  logic [7:0] t_b  [16];
  logic [7:0] o_b  [16];

  always_comb begin
    state_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      in_b[i] = state_i[127 - 8*i -: 8];
      k_b[i]  = rkey_i[127 - 8*i -: 8];
    end
    // Byte i = column*4 + row; row r of column c comes from column (c - r) mod 4.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        t_b[c*4 + r] = inv_sbox(in_b[((c + 4 - r) % 4)*4 + r]) ^ k_b[c*4 + r];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      if (last_i) begin
        for (int unsigned r = 0; r < 4; r++) o_b[c*4 + r] = t_b[c*4 + r];
      end else begin
        o_b[c*4 + 0] = gf_mul(t_b[c*4], 4'he) ^ gf_mul(t_b[c*4+1], 4'hb) ^ gf_mul(t_b[c*4+2], 4'hd) ^ gf_mul(t_b[c*4+3], 4'h9);
        o_b[c*4 + 1] = gf_mul(t_b[c*4], 4'h9) ^ gf_mul(t_b[c*4+1], 4'he) ^ gf_mul(t_b[c*4+2], 4'hb) ^ gf_mul(t_b[c*4+3], 4'hd);
        o_b[c*4 + 2] = gf_mul(t_b[c*4], 4'hd) ^ gf_mul(t_b[c*4+1], 4'h9) ^ gf_mul(t_b[c*4+2], 4'he) ^ gf_mul(t_b[c*4+3], 4'hb);
        o_b[c*4 + 3] = gf_mul(t_b[c*4], 4'hb) ^ gf_mul(t_b[c*4+1], 4'hd) ^ gf_mul(t_b[c*4+2], 4'h9) ^ gf_mul(t_b[c*4+3], 4'he);
      end
    end
    for (int unsigned i = 0; i < 16; i++) state_o[127 - 8*i -: 8] = o_b[i];
  end

endmodule

// File: rtl/aes_256_inv_iter.sv
// Iterative AES-256 decryptor: expands and stores 15 round keys, then one inverse round per cycle.
// Optional `AES_INV_ZEROIZE_EN adds a zeroize input that wipes round keys and state.
module aes_256_inv_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
`ifdef AES_INV_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  aes_inv_state_t state_q, state_d;
  logic [127:0]   rk_q [15];
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   s_q, s_d;
  logic [127:0]   out_q, out_d;
  logic           key_load, rk_we;
  logic [127:0]   prev1, prev2, kexp_word, round_out;
  logic [31:0]    temp, w0, w1, w2, w3;

  aes_inv_round u_round (
    .state_i (s_q),
    .rkey_i  (rk_q[rnd_q]),
    .last_i  (rnd_q == 4'd0),
    .state_o (round_out)
  );

  // Next round key from the two preceding ones; odd steps skip RotWord and rcon.
  always_comb begin
    prev1 = rk_q[idx_q - 4'd1];
    prev2 = rk_q[idx_q - 4'd2];
    if (!idx_q[0]) begin
      temp = sub_word({prev1[23:0], prev1[31:24]}) ^ {AES_RCON[idx_q[3:1]], 24'h0};
    end else begin
      temp = sub_word(prev1[31:0]);
    end
    w0 = prev2[127:96] ^ temp;
    w1 = w0 ^ prev2[95:64];
    w2 = w1 ^ prev2[63:32];
    w3 = w2 ^ prev2[31:0];
    kexp_word = {w0, w1, w2, w3};
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rnd_d    = rnd_q;
    s_d      = s_q;
    out_d    = out_q;
    key_load = 1'b0;
    rk_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          key_load = 1'b1;
          idx_d    = 4'd2;
          state_d  = ST_KEXP;
        end
      end
      ST_KEXP: begin
        rk_we = 1'b1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd14) state_d = ST_READY;
      end
      ST_READY: begin
        if (key_valid) begin
          key_load = 1'b1;
          idx_d    = 4'd2;
          state_d  = ST_KEXP;
        end else if (in_valid) begin
          s_d     = in_data ^ rk_q[14];
          rnd_d   = 4'd13;
          state_d = ST_DEC;
        end
      end
      ST_DEC: begin
        s_d = round_out;
        if (rnd_q == 4'd0) begin
          out_d   = round_out;
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rnd_q   <= '0;
      s_q     <= '0;
      out_q   <= '0;
    end
`ifdef AES_INV_ZEROIZE_EN
    else if (zeroize) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
    end
`endif
    else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rnd_q   <= rnd_d;
      s_q     <= s_d;
      out_q   <= out_d;
    end
  end

  // Round keys carry no reset: IDLE alone marks them invalid.
  always_ff @(posedge clk) begin
`ifdef AES_INV_ZEROIZE_EN
    if (zeroize) begin
      for (int unsigned i = 0; i < 15; i++) rk_q[i] <= '0;
    end else
`endif
    if (!rst) begin
      if (key_load) begin
        rk_q[0] <= key[255:128];
        rk_q[1] <= key[127:0];
      end
      if (rk_we) rk_q[idx_q] <= kexp_word;
    end
  end

  assign key_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign in_ready  = (state_q == ST_READY) && !key_valid;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_KEXP) || (state_q == ST_DEC);
  assign out_data  = out_q;

endmodule

// File: tb/tb_aes_256_inv_iter.sv
// Directed-vector bench for aes_256_inv_iter (FIPS-197 C.3 and SP800-38A F.1.6 vectors).
module tb_aes_256_inv_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         zeroize;
  logic         key_valid, key_ready;
  logic [255:0] key;
  logic         in_valid, in_ready;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [255:0] K1   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C2   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P2   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_256_inv_iter dut (
    .clk       (clk),
    .rst       (rst),
`ifdef AES_INV_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] k);
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (13) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (key_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got kr=%b ir=%b ov=%b busy=%b expected 1 0 0 0", key_ready, in_ready, out_valid, busy);
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = C1;
    tick();
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_block: got ir=%b busy=%b expected 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fips_c3();
    int unsigned bcount, cyc;
    key = K1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    bcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      if (key_ready !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL kexp_key_ready: got %b expected 0", key_ready);
      end
      bcount++;
      tick();
    end
    n_checks++;
    if (bcount != 13) begin
      n_fail++;
      $display("FAIL kexp_busy_cycles: got %0d expected 13", bcount);
    end
    n_checks++;
    if (key_ready !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kexp_done_ready: got kr=%b ir=%b expected 1 1", key_ready, in_ready);
    end
    in_data = C1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 14) begin
      n_fail++;
      $display("FAIL c3_latency: got %0d expected 14", cyc);
    end
    n_checks++;
    if (out_data !== P1) begin
      n_fail++;
      $display("FAIL c3_plaintext: got %h expected %h", out_data, P1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== P1) begin
      n_fail++;
      $display("FAIL c3_handshake: got ov=%b ir=%b data=%h expected 0 1 %h", out_valid, in_ready, out_data, P1);
    end
  endtask

  task automatic test_sp800();
    int unsigned cyc;
    load_key(K2);
    n_checks++;
    if (dut.rk_q[14] !== RK14) begin
      n_fail++;
      $display("FAIL sp800_rk14: got %h expected %h", dut.rk_q[14], RK14);
    end
    in_data = C2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 14 || out_data !== P2) begin
      n_fail++;
      $display("FAIL sp800_plaintext: got %h after %0d cycles expected %h after 14", out_data, cyc, P2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int unsigned cyc;
    in_data = C2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== P2) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b data=%h expected 1 0 %h", i, out_valid, in_ready, out_data, P2);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_accept: got busy=%b ir=%b expected 1 0", busy, in_ready);
    end
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 14 || out_data !== P2) begin
      n_fail++;
      $display("FAIL bp_second_block: got %h after %0d cycles expected %h after 14", out_data, cyc, P2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_key_priority();
    int unsigned bcount, cyc;
    key = K1;
    key_valid = 1'b1;
    in_data = C1;
    in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || key_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_ready: got ir=%b kr=%b expected 0 1", in_ready, key_ready);
    end
    tick();
    key_valid = 1'b0;
    in_valid = 1'b0;
    bcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      if (out_valid !== 1'b0) begin
        n_checks++;
        n_fail++;
        $display("FAIL prio_no_output: got %b expected 0", out_valid);
      end
      bcount++;
      tick();
    end
    n_checks++;
    if (bcount != 13) begin
      n_fail++;
      $display("FAIL prio_busy_cycles: got %0d expected 13", bcount);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 14 || out_data !== P1) begin
      n_fail++;
      $display("FAIL prio_new_key_used: got %h after %0d cycles expected %h after 14", out_data, cyc, P1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_rst_abort();
    in_data = C1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || key_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: got ov=%b kr=%b ir=%b busy=%b expected 0 1 0 0", out_valid, key_ready, in_ready, busy);
    end
    n_checks++;
    if (out_data !== 128'h0) begin
      n_fail++;
      $display("FAIL abort_out_data: got %h expected 0", out_data);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_accept[%0d]: got ir=%b busy=%b ov=%b expected 0 0 0", i, in_ready, busy, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

`ifdef AES_INV_ZEROIZE_EN
  task automatic test_zeroize();
    int unsigned cyc;
    load_key(K2);
    in_data = C2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== P2) begin
      n_fail++;
      $display("FAIL zero_pre_done: got ov=%b data=%h expected 1 %h", out_valid, out_data, P2);
    end
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || dut.state_q !== aes_pkg::ST_IDLE) begin
      n_fail++;
      $display("FAIL zero_idle: got ov=%b kr=%b busy=%b expected 0 1 0 in IDLE", out_valid, key_ready, busy);
    end
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (dut.rk_q[i] !== 128'h0) begin
        n_fail++;
        $display("FAIL zero_rk[%0d]: got %h expected 0", i, dut.rk_q[i]);
      end
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    zeroize   = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_fips_c3();
    test_sp800();
    test_backpressure();
    test_key_priority();
    test_rst_abort();
`ifdef AES_INV_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
